// File: rtl/cfu_simd_mac.sv
// cfu_simd_mac: multi-cycle SIMD dot-product-accumulate unit for the CFU slot.
// It keeps a bank of accumulators. A MAC processes one lane per cycle: lane 0
// in the accept cycle and the remaining lanes in BUSY. The other commands
// finish in the accept cycle. rslt_o is registered and valid in DONE.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef CFU_CTRL_WIDTH
`define CFU_CTRL_WIDTH 11
`endif
`ifndef CFU_CTRL_IS_CFU
`define CFU_CTRL_IS_CFU 0
`endif

module cfu_simd_mac #(
  parameter int LANES = 4,
  parameter int NACC  = 4,
  parameter int ACC_W = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       stall_i,
  input  logic                       valid_i,
  input  logic [`CFU_CTRL_WIDTH-1:0] cfu_ctrl_i,
  input  logic [`XLEN-1:0]           src1_i,
  input  logic [`XLEN-1:0]           src2_i,
  output logic                       stall_o,
  output logic [`XLEN-1:0]           rslt_o
);

  localparam int XLEN = `XLEN;
  localparam int LW   = XLEN / LANES;
  localparam int SELW = (NACC > 1) ? $clog2(NACC) : 1;
  localparam int CNTW = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] OP_MAC     = 3'd0;
  localparam logic [2:0] OP_READ    = 3'd1;
  localparam logic [2:0] OP_CLEAR   = 3'd2;
  localparam logic [2:0] OP_WRITE   = 3'd3;
  localparam logic [2:0] OP_REQUANT = 3'd4;

  // Saturation bounds of a signed LW-bit value, held at accumulator width.
  localparam logic signed [ACC_W-1:0] QMAX = {{(ACC_W-LW+1){1'b0}}, {(LW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] QMIN = {{(ACC_W-LW+1){1'b1}}, {(LW-1){1'b0}}};

  logic [1:0]       state_q,   state_d;
  logic [CNTW-1:0]  laneCnt_q, laneCnt_d;
  logic [XLEN-1:0]  op1_q,     op1_d;
  logic [XLEN-1:0]  op2_q,     op2_d;
  logic             sgn_q,     sgn_d;
  logic [SELW-1:0]  sel_q,     sel_d;
  logic [ACC_W-1:0] sum_q,     sum_d;
  logic [XLEN-1:0]  rslt_q,    rslt_d;
  logic [ACC_W-1:0] acc_q [NACC];

  logic             accWe;
  logic [SELW-1:0]  accWIdx;
  logic [ACC_W-1:0] accWData;

  logic             cmdValid;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [SELW-1:0]  sel;
  logic             sgn;
  logic [ACC_W-1:0] accSel;
  logic [ACC_W-1:0] acceptProd;
  logic [ACC_W-1:0] busyProd;
  logic [ACC_W-1:0] macSum;
  logic [4:0]       shAmt;
  logic signed [ACC_W-1:0] shifted;
  logic signed [ACC_W-1:0] requantVal;
  logic             unusedBits;

  // Product of one lane pair, widened to the accumulator width.
  function automatic logic [ACC_W-1:0] laneProd(input logic [LW-1:0] a,
                                                input logic [LW-1:0] b,
                                                input logic          s);
    logic signed [2*LW-1:0] ea, eb, ps;
    logic [2*LW-1:0] ua, ub, pu;
    ea = {{LW{a[LW-1]}}, a};
    eb = {{LW{b[LW-1]}}, b};
    ps = ea * eb;
    ua = {{LW{1'b0}}, a};
    ub = {{LW{1'b0}}, b};
    pu = ua * ub;
    return s ? ACC_W'(ps) : ACC_W'(pu);
  endfunction

  // Accumulator-width values are reported sign-extended to the register width.
  function automatic logic [XLEN-1:0] sextAcc(input logic [ACC_W-1:0] v);
    return XLEN'($signed(v));
  endfunction

  assign funct3   = cfu_ctrl_i[3:1];
  assign funct7   = cfu_ctrl_i[10:4];
  assign cmdValid = valid_i && cfu_ctrl_i[`CFU_CTRL_IS_CFU];
  assign sel      = (NACC > 1) ? funct7[SELW-1:0] : '0;
  assign sgn      = !funct7[6];
  assign accSel   = acc_q[sel];

  assign stall_o  = ((state_q == ST_IDLE) && cmdValid) || (state_q == ST_BUSY);
  assign rslt_o   = rslt_q;

  assign unusedBits = ^{cfu_ctrl_i, funct7};

  // Lane products for the accept cycle (live operands) and BUSY (latched ones).
  always_comb begin
    acceptProd = laneProd(src1_i[LW-1:0], src2_i[LW-1:0], sgn);
    busyProd   = laneProd(op1_q[int'(laneCnt_q)*LW +: LW],
                          op2_q[int'(laneCnt_q)*LW +: LW], sgn_q);
  end

  // Requantize: clamp shift, arithmetic shift, then saturate to a signed lane.
  always_comb begin
    shAmt = src2_i[4:0];
    if (int'(src2_i[4:0]) > ACC_W - 1) begin
      shAmt = 5'(ACC_W - 1);
    end
    shifted = $signed(accSel) >>> shAmt;
    if (shifted > QMAX) begin
      requantVal = QMAX;
    end else if (shifted < QMIN) begin
      requantVal = QMIN;
    end else begin
      requantVal = shifted;
    end
  end

  // Command sequencing; the accumulator bank is written at most once per command.
  always_comb begin
    state_d   = state_q;
    laneCnt_d = laneCnt_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    sgn_d     = sgn_q;
    sel_d     = sel_q;
    sum_d     = sum_q;
    rslt_d    = rslt_q;
    accWe     = 1'b0;
    accWIdx   = sel_q;
    accWData  = sum_q;
    macSum    = '0;
    case (state_q)
      ST_IDLE: begin
        if (cmdValid) begin
          op1_d   = src1_i;
          op2_d   = src2_i;
          sgn_d   = sgn;
          sel_d   = sel;
          accWIdx = sel;
          state_d = ST_DONE;
          case (funct3)
            OP_MAC: begin
              macSum = accSel + acceptProd;
              if (LANES == 1) begin
                accWe    = 1'b1;
                accWData = macSum;
                rslt_d   = sextAcc(macSum);
              end else begin
                sum_d     = macSum;
                laneCnt_d = CNTW'(1);
                state_d   = ST_BUSY;
              end
            end
            OP_READ: begin
              rslt_d = sextAcc(accSel);
            end
            OP_CLEAR: begin
              rslt_d   = sextAcc(accSel);
              accWe    = 1'b1;
              accWData = '0;
            end
            OP_WRITE: begin
              accWe    = 1'b1;
              accWData = src1_i[ACC_W-1:0];
              rslt_d   = sextAcc(src1_i[ACC_W-1:0]);
            end
            OP_REQUANT: begin
              rslt_d = sextAcc(requantVal);
            end
            default: begin
              rslt_d = '0;
            end
          endcase
        end
      end
      ST_BUSY: begin
        macSum = sum_q + busyProd;
        if (laneCnt_q == CNTW'(LANES - 1)) begin
          accWe     = 1'b1;
          accWData  = macSum;
          rslt_d    = sextAcc(macSum);
          laneCnt_d = '0;
          state_d   = ST_DONE;
        end else begin
          sum_d     = macSum;
          laneCnt_d = CNTW'(laneCnt_q + 1'b1);
        end
      end
      ST_DONE: begin
        if (!stall_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and datapath registers; reset drops any in-flight command.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      laneCnt_q <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      sgn_q     <= 1'b0;
      sel_q     <= '0;
      sum_q     <= '0;
      rslt_q    <= '0;
    end else begin
      state_q   <= state_d;
      laneCnt_q <= laneCnt_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      sgn_q     <= sgn_d;
      sel_q     <= sel_d;
      sum_q     <= sum_d;
      rslt_q    <= rslt_d;
    end
  end

  // Accumulator bank with a single write port.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NACC; i++) begin
        acc_q[i] <= '0;
      end
    end else if (accWe) begin
      acc_q[accWIdx] <= accWData;
    end
  end

endmodule
